// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks: FSM encoding, slice width, counter sizing.
// Pure declarations: no latency, no flow control.
package adder_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-slice operation still needs a 1-bit counter.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ripple_adder.sv
// Combinational N-bit ripple-carry adder; index 0 is the carry-in end.
// Zero latency, no flow control.
module ripple_adder
    import adder_pkg::*;
#(
    parameter int N = NIBBLE
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] s_o,
    output logic         cout_o
);

    logic [N:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[N];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder run one 4-bit slice per cycle through a shared ripple_adder; latency WIDTH/4 cycles.
// in_ready only while idle; the result holds in DONE until out_ready, so downstream stalls block new work.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB = WIDTH / NIBBLE;
    localparam int CW  = ctr_width(NIB);

    state_e            state_q,  state_d;
    logic [WIDTH-1:0]  a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]  b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic              carry_q,  carry_d;
    logic [CW-1:0]     cnt_q,    cnt_d;

    logic [NIBBLE-1:0] nib_s;
    logic              nib_cout;

    ripple_adder #(
        .N      (NIBBLE)
    ) u_slice (
        .a_i    (a_sh_q[NIBBLE-1:0]),
        .b_i    (b_sh_q[NIBBLE-1:0]),
        .cin_i  (carry_q),
        .s_o    (nib_s),
        .cout_o (nib_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> NIBBLE;
                b_sh_d   = b_sh_q >> NIBBLE;
                // Each new slice lands at the top; after NIB shifts slice 0 sits at the LSB.
                sum_sh_d = (sum_sh_q >> NIBBLE) | (WIDTH'(nib_s) << (WIDTH - NIBBLE));
                carry_d  = nib_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(NIB - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Partial sums never leak: sum/cout read zero except while the result is valid.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = out_valid ? sum_sh_q : '0;
    assign cout      = out_valid & carry_q;

endmodule
